// File: rtl/systolic_pkg.sv
// systolic_pkg: shared types and sizing helpers for the systolic array datapath.
package systolic_pkg;
  typedef enum logic [1:0] {IDLE, STREAM, DONE} streamerStateType;
  function automatic int minFifoDepth(input int readLatency);
    return readLatency + 1;
  endfunction
endpackage

// File: rtl/dff.sv
// dff: plain synchronous-reset register cell.
module dff #(
  parameter int width = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);
  always_ff @(posedge clk) q <= rst ? '0 : d;
endmodule

// File: rtl/stream_fifo.sv
// stream_fifo: small circular FIFO with synchronous flush; push and pop may coincide.
module stream_fifo #(
  parameter int dataWidth = 32,
  parameter int fifoDepth = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [dataWidth-1:0]           pushData,
  input  logic                           pop,
  input  logic                           flush,
  output logic [dataWidth-1:0]           head,
  output logic                           empty,
  output logic                           full,
  output logic [$clog2(fifoDepth+1)-1:0] count
);
  localparam int pw = fifoDepth > 1 ? $clog2(fifoDepth) : 1;
  localparam int cw = $clog2(fifoDepth + 1);
  logic [dataWidth-1:0] mem [fifoDepth];
  logic [pw-1:0] rdPtr, wrPtr;
  logic wr, rd;
  function automatic logic [pw-1:0] nextPtr(input logic [pw-1:0] p);
    return p == pw'(fifoDepth - 1) ? '0 : p + 1'b1;
  endfunction
  assign empty = count == '0;
  assign full = count == cw'(fifoDepth);
  assign wr = push && (!full || pop);
  assign rd = pop && !empty;
  assign head = mem[rdPtr];
  always_ff @(posedge clk) if (wr) mem[wrPtr] <= pushData;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      wrPtr <= wr ? nextPtr(wrPtr) : wrPtr;
      rdPtr <= rd ? nextPtr(rdPtr) : rdPtr;
      count <= count + cw'(wr) - cw'(rd);
    end
  end
endmodule

// File: rtl/axis_result_streamer.sv
// axis_result_streamer: drains the result memory onto M_AXIS with credit-limited reads
// and a small output FIFO absorbing read latency and back-pressure.
module axis_result_streamer
  import systolic_pkg::*;
#(
  parameter int words = 2,
  parameter int dataWidth = 32,
  parameter int addressWidth = words > 1 ? $clog2(words) : 1,
  parameter int readLatency = 1,
  parameter int fifoDepth = minFifoDepth(readLatency)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  output logic                    readEnable,
  output logic [addressWidth-1:0] readAddress,
  input  logic [dataWidth-1:0]    readData,
  output logic                    M_AXIS_TVALID,
  input  logic                    M_AXIS_TREADY,
  output logic [dataWidth-1:0]    M_AXIS_TDATA,
  output logic                    M_AXIS_TLAST,
  output logic                    busy,
  output logic                    done
);
  localparam int cw = $clog2(words + 1);
  localparam int fw = $clog2(fifoDepth + 1);
  localparam int iw = $clog2(readLatency + 1);
  streamerStateType state, nextState;
  logic [cw-1:0] issueCount, beatCount;
  logic [readLatency-1:0] pipeValid;
  logic [iw-1:0] inFlight;
  logic [fw-1:0] fifoCount;
  logic [dataWidth-1:0] fifoHead;
  logic fifoEmpty, fifoFull, accept, handshake, lastBeat, creditOk, issue;
  assign accept = state == IDLE && start && !abort;
  assign handshake = M_AXIS_TVALID && M_AXIS_TREADY;
  assign lastBeat = beatCount == cw'(words - 1);
  // A pop this cycle frees its slot in time for the new read, giving full throughput.
  assign creditOk = int'(inFlight) + int'(fifoCount) - int'(handshake) < fifoDepth;
  assign issue = !abort && creditOk && (accept || (state == STREAM && issueCount < cw'(words)));
  assign readEnable = issue;
  assign M_AXIS_TVALID = !fifoEmpty;
  assign M_AXIS_TDATA = fifoEmpty ? '0 : fifoHead;
  assign M_AXIS_TLAST = !fifoEmpty && lastBeat;
  always_comb begin
    inFlight = '0;
    for (int i = 0; i < readLatency; i++) inFlight = inFlight + iw'(pipeValid[i]);
  end
  always_comb
    nextState = abort ? IDLE
      : state == IDLE ? (start ? STREAM : IDLE)
      : state == STREAM ? (handshake && lastBeat ? DONE : STREAM)
      : IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      issueCount <= '0;
      beatCount <= '0;
      readAddress <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nextState;
      busy <= nextState == STREAM;
      done <= nextState == DONE;
      issueCount <= abort ? '0 : issue ? (accept ? '0 : issueCount) + 1'b1 : issueCount;
      readAddress <= abort ? '0
        : !issue ? readAddress
        : readAddress == addressWidth'(words - 1) ? '0
        : readAddress + 1'b1;
      beatCount <= abort || accept ? '0 : handshake ? beatCount + 1'b1 : beatCount;
    end
  end
  for (genvar i = 0; i < readLatency; i++) begin : genPipe
    if (i == 0) begin : genFirst
      dff validStage (.clk(clk), .rst(rst), .d(issue), .q(pipeValid[0]));
    end else begin : genNext
      dff validStage (.clk(clk), .rst(rst), .d(pipeValid[i-1] && !abort), .q(pipeValid[i]));
    end
  end
  stream_fifo #(.dataWidth(dataWidth), .fifoDepth(fifoDepth)) outFifo (
    .clk(clk),
    .rst(rst),
    .push(pipeValid[readLatency-1]),
    .pushData(readData),
    .pop(handshake),
    .flush(abort),
    .head(fifoHead),
    .empty(fifoEmpty),
    .full(fifoFull),
    .count(fifoCount)
  );
  noOverflow: assert property (@(posedge clk) disable iff (rst)
    !(pipeValid[readLatency-1] && fifoFull && !handshake && !abort));
endmodule

// File: tb/tb_axis_result_streamer.sv
// tb_axis_result_streamer: directed vector table plus hand sequences over three configurations.
module tb_axis_result_streamer;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;

  logic stA = 0, abA = 0, trA = 1, reA, tvA, tlA, bA, dA;
  logic [1:0] raA;
  logic [31:0] rdA, tdA;
  logic stB = 0, abB = 0, trB = 1, reB, tvB, tlB, bB, dB;
  logic [2:0] raB;
  logic [31:0] rdB, tdB;
  logic stC = 0, abC = 0, trC = 1, reC, tvC, tlC, bC, dC;
  logic [0:0] raC;
  logic [31:0] rdC, tdC;

  axis_result_streamer #(.words(4), .readLatency(1)) dutA (
    .clk(clk), .rst(rst), .start(stA), .abort(abA), .readEnable(reA), .readAddress(raA),
    .readData(rdA), .M_AXIS_TVALID(tvA), .M_AXIS_TREADY(trA), .M_AXIS_TDATA(tdA),
    .M_AXIS_TLAST(tlA), .busy(bA), .done(dA));
  axis_result_streamer #(.words(8), .readLatency(3)) dutB (
    .clk(clk), .rst(rst), .start(stB), .abort(abB), .readEnable(reB), .readAddress(raB),
    .readData(rdB), .M_AXIS_TVALID(tvB), .M_AXIS_TREADY(trB), .M_AXIS_TDATA(tdB),
    .M_AXIS_TLAST(tlB), .busy(bB), .done(dB));
  axis_result_streamer #(.words(1), .readLatency(1)) dutC (
    .clk(clk), .rst(rst), .start(stC), .abort(abC), .readEnable(reC), .readAddress(raC),
    .readData(rdC), .M_AXIS_TVALID(tvC), .M_AXIS_TREADY(trC), .M_AXIS_TDATA(tdC),
    .M_AXIS_TLAST(tlC), .busy(bC), .done(dC));

  // Memory models: data only appears for a real read, so misaligned pushes show up as BAD0_0000.
  logic [31:0] memA [4];
  logic [31:0] pB [3];
  initial memA = '{32'h10, 32'h11, 32'h12, 32'h13};
  always @(posedge clk) rdA <= reA ? memA[raA] : 32'hBAD0_0000;
  always @(posedge clk) begin
    pB[0] <= reB ? 32'h20 + 32'(raB) : 32'hBAD0_0000;
    pB[1] <= pB[0];
    pB[2] <= pB[1];
  end
  assign rdB = pB[2];
  always @(posedge clk) rdC <= reC ? 32'hAB : 32'hBAD0_0000;

  typedef struct {
    bit c, r, s, a, t;
    bit re;
    int ra;
    bit tv;
    logic [31:0] td;
    bit tl, b, d;
  } vecType;
  vecType vecs[$];
  int checks = 0, errors = 0;

  function automatic void add(bit c, bit r, bit s, bit a, bit t, bit re, int ra, bit tv,
                              logic [31:0] td, bit tl, bit b, bit d);
    vecs.push_back('{c, r, s, a, t, re, ra, tv, td, tl, b, d});
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    //   c r s a t   re ra tv td      tl b d
    add(0,0,0,0,1,  0, 0, 0, 32'h0,  0, 0, 0);  // reset state
    add(0,0,1,0,1,  1, 0, 0, 32'h0,  0, 0, 0);  // start, ready held high
    add(0,0,0,0,1,  1, 1, 0, 32'h0,  0, 1, 0);
    add(0,0,0,0,1,  1, 2, 1, 32'h10, 0, 1, 0);
    add(0,0,1,0,1,  1, 3, 1, 32'h11, 0, 1, 0);  // start while busy ignored
    add(0,0,0,0,1,  0, 0, 1, 32'h12, 0, 1, 0);
    add(0,0,0,0,1,  0, 0, 1, 32'h13, 1, 1, 0);
    add(0,0,1,0,1,  0, 0, 0, 32'h0,  0, 0, 1);  // start in DONE ignored
    add(0,0,0,0,1,  0, 0, 0, 32'h0,  0, 0, 0);
    add(0,0,1,1,1,  0, 0, 0, 32'h0,  0, 0, 0);  // start with abort
    add(0,0,0,0,1,  0, 0, 0, 32'h0,  0, 0, 0);
    add(0,0,1,0,1,  1, 0, 0, 32'h0,  0, 0, 0);  // abort after second handshake
    add(0,0,0,0,1,  1, 1, 0, 32'h0,  0, 1, 0);
    add(0,0,0,0,1,  1, 2, 1, 32'h10, 0, 1, 0);
    add(0,0,0,0,1,  1, 3, 1, 32'h11, 0, 1, 0);
    add(0,0,0,1,0,  0, 0, 1, 32'h12, 0, 1, 0);
    add(0,0,0,0,1,  0, 0, 0, 32'h0,  0, 0, 0);
    add(0,0,0,0,1,  0, 0, 0, 32'h0,  0, 0, 0);
    add(0,0,1,0,1,  1, 0, 0, 32'h0,  0, 0, 0);  // restart from address 0
    add(0,0,0,0,1,  1, 1, 0, 32'h0,  0, 1, 0);
    add(0,0,0,0,1,  1, 2, 1, 32'h10, 0, 1, 0);
    add(0,1,0,0,1,  1, 3, 1, 32'h11, 0, 1, 0);  // reset mid-stream
    add(0,0,0,0,1,  0, 0, 0, 32'h0,  0, 0, 0);
    add(0,0,1,0,1,  1, 0, 0, 32'h0,  0, 0, 0);
    add(0,0,0,0,1,  1, 1, 0, 32'h0,  0, 1, 0);
    add(0,0,0,0,1,  1, 2, 1, 32'h10, 0, 1, 0);
    add(0,0,0,0,1,  1, 3, 1, 32'h11, 0, 1, 0);
    add(0,0,0,0,1,  0, 0, 1, 32'h12, 0, 1, 0);
    add(0,0,0,0,1,  0, 0, 1, 32'h13, 1, 1, 0);
    add(0,0,0,0,1,  0, 0, 0, 32'h0,  0, 0, 1);
    add(0,0,0,0,1,  0, 0, 0, 32'h0,  0, 0, 0);
    add(1,0,1,0,1,  1, 0, 0, 32'h0,  0, 0, 0);  // single-word transfer
    add(1,0,0,0,1,  0, 0, 0, 32'h0,  0, 1, 0);
    add(1,0,0,0,1,  0, 0, 1, 32'hAB, 1, 1, 0);
    add(1,0,0,0,1,  0, 0, 0, 32'h0,  0, 0, 1);
    add(1,0,0,0,1,  0, 0, 0, 32'h0,  0, 0, 0);
    repeat (3) @(posedge clk);
    for (int n = 0; n < vecs.size(); n++) begin
      vecType v;
      v = vecs[n];
      @(posedge clk); #1;
      rst = v.r;
      stA = !v.c && v.s; abA = !v.c && v.a; trA = v.c || v.t;
      stC = v.c && v.s;  abC = v.c && v.a;  trC = !v.c || v.t;
      #2;
      check("readEnable", n, v.c ? reC : reA, v.re);
      check("readAddress", n, v.c ? 32'(raC) : 32'(raA), v.ra);
      check("tvalid", n, v.c ? tvC : tvA, v.tv);
      check("tdata", n, v.c ? tdC : tdA, v.td);
      check("tlast", n, v.c ? tlC : tlA, v.tl);
      check("busy", n, v.c ? bC : bA, v.b);
      check("done", n, v.c ? dC : dA, v.d);
    end

    // Alternating ready: payload must hold while stalled.
    begin
      int beats = 0, dones = 0, unstable = 0;
      logic [31:0] pd = 0;
      logic pl = 0, hold = 0;
      @(posedge clk); #1;
      stA = 1; abA = 0; trA = 1; stC = 0; abC = 0;
      for (int c = 0; c < 40; c++) begin
        #2;
        if (hold && (!tvA || tdA !== pd || tlA !== pl)) unstable++;
        if (tvA && trA) begin
          check("alt data", beats, tdA, 32'h10 + 32'(beats));
          check("alt last", beats, tlA, beats == 3);
          beats++;
        end
        hold = tvA && !trA; pd = tdA; pl = tlA;
        dones += int'(dA);
        @(posedge clk); #1;
        stA = 0; trA = (c % 2) == 1;
      end
      check("alt beats", 0, beats, 4);
      check("alt stable", 0, unstable, 0);
      check("alt dones", 0, dones, 1);
    end

    // Long latency with a ready gap: credits cap outstanding reads at fifo depth.
    begin
      int beats = 0, dones = 0, issued = 0, maxOut = 0;
      @(posedge clk); #1;
      stB = 1; trB = 1; trA = 1;
      for (int c = 0; c < 60; c++) begin
        #2;
        if (reB) issued++;
        if (c == 3 || c == 4) check("lat tvalid", c, tvB, c == 4);
        if (c == 8) check("lat stall", c, reB, 0);
        if (tvB && trB) begin
          check("lat data", beats, tdB, 32'h20 + 32'(beats));
          check("lat last", beats, tlB, beats == 7);
          beats++;
        end
        if (issued - beats > maxOut) maxOut = issued - beats;
        dones += int'(dB);
        @(posedge clk); #1;
        stB = 0; trB = !(c + 1 >= 3 && c + 1 <= 12);
      end
      check("lat beats", 0, beats, 8);
      check("lat issued", 0, issued, 8);
      check("lat outstanding", 0, maxOut, 4);
      check("lat dones", 0, dones, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
